// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak-f[1600] round sequencer: geometry constants,
// step indices and the sequencer state encoding.
package keccak_pkg;

  localparam int SLICES    = 64;
  localparam int LANE_BITS = 25;
  localparam int ROUNDS    = 24;
  localparam int STEPS     = 5;

  typedef enum logic [2:0] {
    STEP_THETA = 3'd0,
    STEP_RHO   = 3'd1,
    STEP_PI    = 3'd2,
    STEP_CHI   = 3'd3,
    STEP_IOTA  = 3'd4
  } step_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_BLANK,
    ST_RUN,
    ST_ADV,
    ST_FINISH,
    ST_ERROR
  } seq_state_e;

  // A permutation is in flight from the first CLEAR until the last ADV.
  function automatic logic seq_busy(input seq_state_e st);
    return (st == ST_CLEAR) || (st == ST_BLANK) || (st == ST_RUN) || (st == ST_ADV);
  endfunction

  // Only the engine being started or running may touch the slice memory.
  function automatic logic seq_port_en(input seq_state_e st);
    return (st == ST_BLANK) || (st == ST_RUN);
  endfunction

endpackage

// File: rtl/keccak_round_sequencer_if.sv
// Sequencer-facing bundle: host handshake, per-engine control/memory ports and
// the single slice-memory port.
interface keccak_round_sequencer_if
  import keccak_pkg::*;
#(
  parameter int NUM_STEPS = STEPS,
  parameter int ADDR_W    = $clog2(SLICES),
  parameter int DATA_W    = LANE_BITS
) ();

  logic                        start;
  logic                        busy;
  logic                        done;
  logic                        err;
  logic [4:0]                  round_idx;
  logic [NUM_STEPS-1:0]        step_clear;
  logic [NUM_STEPS-1:0]        step_start;
  logic [NUM_STEPS-1:0]        step_done;
  logic [NUM_STEPS*ADDR_W-1:0] step_mem_adr;
  logic [NUM_STEPS*DATA_W-1:0] step_mem_in;
  logic [NUM_STEPS-1:0]        step_mem_r;
  logic [NUM_STEPS-1:0]        step_mem_w;
  logic [ADDR_W-1:0]           mem_adr;
  logic [DATA_W-1:0]           mem_in;
  logic                        mem_r;
  logic                        mem_w;

  modport master (
    input  start, step_done, step_mem_adr, step_mem_in, step_mem_r, step_mem_w,
    output busy, done, err, round_idx, step_clear, step_start,
           mem_adr, mem_in, mem_r, mem_w
  );

  modport slave (
    output start, step_done, step_mem_adr, step_mem_in, step_mem_r, step_mem_w,
    input  busy, done, err, round_idx, step_clear, step_start,
           mem_adr, mem_in, mem_r, mem_w
  );

endinterface

// File: rtl/keccak_mem_port_mux.sv
// Zero-latency select of one engine's slice-memory port by step index; when
// disabled the memory sees an all-zero, strobe-free port.
module keccak_mem_port_mux #(
  parameter int NUM_STEPS = 5,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 25,
  parameter int SEL_W     = 3
) (
  input  logic                        en,
  input  logic [SEL_W-1:0]            sel,
  input  logic [NUM_STEPS*ADDR_W-1:0] step_mem_adr,
  input  logic [NUM_STEPS*DATA_W-1:0] step_mem_in,
  input  logic [NUM_STEPS-1:0]        step_mem_r,
  input  logic [NUM_STEPS-1:0]        step_mem_w,
  output logic [ADDR_W-1:0]           mem_adr,
  output logic [DATA_W-1:0]           mem_in,
  output logic                        mem_r,
  output logic                        mem_w
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no path can infer a latch.
    mem_adr = '0;
    mem_in  = '0;
    mem_r   = 1'b0;
    mem_w   = 1'b0;
    if (en) begin
      for (int k = 0; k < NUM_STEPS; k++) begin
        if (sel == SEL_W'(k)) begin
          mem_adr = step_mem_adr[k*ADDR_W +: ADDR_W];
          mem_in  = step_mem_in[k*DATA_W +: DATA_W];
          mem_r   = step_mem_r[k];
          mem_w   = step_mem_w[k];
        end
      end
    end
  end

endmodule

// File: rtl/keccak_round_sequencer.sv
// Runs theta..iota for every round of one Keccak-f[1600] permutation, one engine
// at a time, with a per-step watchdog and a routed slice-memory port.
module keccak_round_sequencer
  import keccak_pkg::*;
#(
  parameter int NUM_ROUNDS = ROUNDS,
  parameter int NUM_STEPS  = STEPS,
  parameter int ADDR_W     = $clog2(SLICES),
  parameter int DATA_W     = LANE_BITS,
  parameter int TIMEOUT    = 1024
) (
  input logic                      clock,
  input logic                      reset,
  keccak_round_sequencer_if.master bus
);

  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(NUM_STEPS - 1);
  localparam logic [4:0]        LAST_ROUND = 5'(NUM_ROUNDS - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX   = WDOG_W'(TIMEOUT - 1);

  seq_state_e           state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [4:0]           round_q, round_d;
  logic [WDOG_W-1:0]    wdog_q, wdog_d;
  logic [NUM_STEPS-1:0] step_oh;
  logic                 active_done;
  logic                 port_en;

  assign step_oh     = NUM_STEPS'(1) << step_q;
  // Done lines of idle engines are masked off here, never looked at again.
  assign active_done = |(bus.step_done & step_oh);
  assign port_en     = seq_port_en(state_q);

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      round_q <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      round_q <= round_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    round_d = round_q;
    wdog_d  = '0;
    unique case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (bus.start) begin
          state_d = ST_CLEAR;
          step_d  = '0;
          round_d = '0;
        end
      end
      ST_CLEAR: state_d = ST_BLANK;
      // The engine's done is still stale from its previous run in BLANK.
      ST_BLANK: state_d = ST_RUN;
      ST_RUN: begin
        if (active_done) begin
          state_d = ST_ADV;
        end else if (wdog_q == WDOG_MAX) begin
          state_d = ST_ERROR;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_ADV: begin
        if (step_q != LAST_STEP) begin
          step_d  = step_q + 1'b1;
          state_d = ST_CLEAR;
        end else if (round_q != LAST_ROUND) begin
          round_d = round_q + 1'b1;
          step_d  = '0;
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign bus.busy       = seq_busy(state_q);
  assign bus.done       = (state_q == ST_FINISH);
  assign bus.err        = (state_q == ST_ERROR);
  assign bus.round_idx  = round_q;
  assign bus.step_clear = (state_q == ST_CLEAR) ? step_oh : '0;
  assign bus.step_start = port_en ? step_oh : '0;

  keccak_mem_port_mux #(
    .NUM_STEPS (NUM_STEPS),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .SEL_W     (STEP_W)
  ) u_mem_mux (
    .en           (port_en),
    .sel          (step_q),
    .step_mem_adr (bus.step_mem_adr),
    .step_mem_in  (bus.step_mem_in),
    .step_mem_r   (bus.step_mem_r),
    .step_mem_w   (bus.step_mem_w),
    .mem_adr      (bus.mem_adr),
    .mem_in       (bus.mem_in),
    .mem_r        (bus.mem_r),
    .mem_w        (bus.mem_w)
  );

endmodule

// File: doc/keccak_round_sequencer.md
Name: keccak_round_sequencer

Overview:
Sequences the five Keccak-f[1600] step engines (theta, rho, pi, chi, iota) over all rounds of one permutation. Every engine works slice-by-slice on the shared 64 x 25-bit slice memory. The sequencer clears and starts one engine at a time and routes that engine's memory port to the single memory. It also supplies the round index to iota, watches each step with a watchdog, and reports completion or error to the top-level hash controller.

Parameters:
NUM_ROUNDS, 24, permutation rounds (5-bit round counter; max 32)
NUM_STEPS, 5, step engines; index order 0=theta,1=rho,2=pi,3=chi,4=iota
ADDR_W, 6, slice memory address width (64 slices)
DATA_W, 25, slice width (5x5 bits)
TIMEOUT, 1024, max cycles a step may run before error

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin permutation; sampled only in IDLE/ERROR
busy  out  1  high from accepted start until done/error
done  out  1  one-cycle pulse when the final round's iota finishes
err  out  1  sticky watchdog error flag
round_idx  out  5  current round, 0..NUM_ROUNDS-1, to iota engine
step_clear  out  NUM_STEPS  one-hot, one-cycle clear of the engine's slice counter/done
step_start  out  NUM_STEPS  one-hot level start, held while engine runs
step_done  in  NUM_STEPS  per-engine done (level)
step_mem_adr  in  NUM_STEPS*ADDR_W  flattened engine addresses, engine k at [k*ADDR_W +: ADDR_W]
step_mem_in  in  NUM_STEPS*DATA_W  flattened engine write data
step_mem_r  in  NUM_STEPS  engine read strobes
step_mem_w  in  NUM_STEPS  engine write strobes
mem_adr  out  ADDR_W  to slice memory
mem_in  out  DATA_W  to slice memory
mem_r  out  1  to slice memory
mem_w  out  1  to slice memory
(Memory read data is broadcast directly to all engines; it does not pass through this block.)

Behaviour:
- Reset values (all outputs): busy=0, done=0, err=0, round_idx=0, step_clear=0, step_start=0, mem_adr=0, mem_in=0, mem_r=0, mem_w=0. State=IDLE, step=0, watchdog=0.
- Reset mid-operation returns to these values on the next edge; no partial completion is signalled.
- States: IDLE, CLEAR, BLANK, RUN, ADV, FINISH, ERROR.
- IDLE: start=1 -> CLEAR. Set round=0, step=0, busy=1.
- CLEAR: step_clear[step]=1 for exactly this cycle -> BLANK.
- BLANK: step_start[step]=1. step_done is ignored this cycle because it is stale. -> RUN.
- RUN: step_start[step]=1 and watchdog increments.
  - step_done[step]=1 -> ADV; step_start drops at the next edge.
  - Watchdog reaches TIMEOUT-1 without done -> ERROR.
  - step_done of non-active engines is ignored.
- ADV: watchdog=0.
  - step<NUM_STEPS-1: step++ -> CLEAR.
  - Else, round<NUM_ROUNDS-1: round++, step=0 -> CLEAR.
  - Else -> FINISH.
- FINISH: done=1 for one cycle, busy=0 -> IDLE.
- ERROR: err=1 (sticky), busy=0, all start/clear and memory strobes low.
  - start=1 clears err and restarts exactly as from IDLE.
- start is ignored outside IDLE/ERROR; no queuing.
- Memory mux is combinational on the registered step index, with zero latency from the engine outputs.
  - In BLANK/RUN the mux passes the engine's adr, in, r and w.
  - In all other states mem_r=mem_w=0 and adr/in=0.
  - Strobes of non-selected engines never reach memory.
- round_idx is stable for all five steps of a round; it changes only in ADV on the step 4 -> 0 wrap.
- Overhead: 3 cycles per step (CLEAR, BLANK, ADV) plus engine run time, plus 1 FINISH cycle.
  - With an engine done after N RUN cycles: total = 120*(N+3)+1 cycles from start acceptance to done.

Decomposition:
- Shared package keccak_pkg:
  - State enum.
  - STEP_THETA..STEP_IOTA index constants.
  - SLICES=64, LANE_BITS=25, ROUNDS=24.
- One sub-module, keccak_mem_port_mux: the combinational one-hot/index select of the flattened engine memory ports, with an enable input for idle gating.

Test Plan:
- Stub engines finish in 64 RUN cycles; start pulse -> step_start order 0,1,2,3,4 repeated 24 times, done pulses once at cycle 120*67+1=8041, busy low afterward.
- round_idx trace -> 0 for first five steps, 23 during final iota, never 24. step_clear precedes every step_start by exactly 1 cycle.
- Chi stub (index 3) writes adr=5 data=25'h1ABCDEF with mem_w, while idle theta stub drives mem_w=1 adr=9 -> memory sees only adr=5/data 25'h1ABCDEF, mem_w from theta never propagates.
- Iota stub never asserts done with TIMEOUT=1024 -> err=1 after 1024 RUN cycles in round 0, busy=0, all strobes 0. A new start clears err and restarts at round 0 step 0.
- reset=1 for one cycle during round 7 chi -> next cycle all outputs at reset values; start then runs a full clean 24-round sequence.
- start held high throughout, plus spurious step_done on non-active engines and stale done during BLANK -> no skipped steps, exactly one done pulse, busy stays 1 until done.
